// File: rtl/celement_merge_sync.sv
// Two-input four-phase token merge: joins branch A/B tokens onto one channel with a source tag.
// Optional macro CELEMENT_MERGE_TIMEOUT_EN adds a sticky REQ-phase timeout flag on err.
module celement_merge_sync #(
  parameter int DW             = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sendina,
  input  logic [DW-1:0] dataina,
  output logic          ackouta,
  input  logic          sendinb,
  input  logic [DW-1:0] datainb,
  output logic          ackoutb,
  output logic          sendout,
  output logic [DW-1:0] dataout,
  output logic          brout,
  input  logic          ackin,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] dataout_nxt;
  logic          brout_nxt;
  logic          sendout_nxt;
  logic          ackouta_nxt;
  logic          ackoutb_nxt;
  logic          last_b, last_b_nxt;
  logic          grant_a, grant_b;
  logic          src_send;

  generate
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("celement_merge_sync: TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  // On a tie the branch that did not win last time is granted.
  assign grant_a  = sendina & (~sendinb | last_b);
  assign grant_b  = sendinb & (~sendina | ~last_b);
  assign src_send = brout ? sendinb : sendina;

  always_comb begin
    state_nxt   = state;
    dataout_nxt = dataout;
    brout_nxt   = brout;
    sendout_nxt = sendout;
    ackouta_nxt = ackouta;
    ackoutb_nxt = ackoutb;
    last_b_nxt  = last_b;
    case (state)
      IDLE: begin
        if (grant_a) begin
          dataout_nxt = dataina;
          brout_nxt   = 1'b0;
          sendout_nxt = 1'b1;
          last_b_nxt  = 1'b0;
          state_nxt   = REQ;
        end else if (grant_b) begin
          dataout_nxt = datainb;
          brout_nxt   = 1'b1;
          sendout_nxt = 1'b1;
          last_b_nxt  = 1'b1;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        if (ackin) begin
          sendout_nxt = 1'b0;
          ackouta_nxt = ~brout;
          ackoutb_nxt = brout;
          state_nxt   = ACK;
        end
      end
      ACK: begin
        if (!ackin && !src_send) begin
          ackouta_nxt = 1'b0;
          ackoutb_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      dataout <= '0;
      brout   <= 1'b0;
      sendout <= 1'b0;
      ackouta <= 1'b0;
      ackoutb <= 1'b0;
      last_b  <= 1'b1;
    end else begin
      state   <= state_nxt;
      dataout <= dataout_nxt;
      brout   <= brout_nxt;
      sendout <= sendout_nxt;
      ackouta <= ackouta_nxt;
      ackoutb <= ackoutb_nxt;
      last_b  <= last_b_nxt;
    end
  end

`ifdef CELEMENT_MERGE_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tcount;
  logic          err_q;

  // Counter saturates at the threshold so a very long stall cannot wrap it.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcount <= '0;
      err_q  <= 1'b0;
    end else if (state == IDLE && state_nxt == REQ) begin
      tcount <= '0;
    end else if (state == REQ && !ackin) begin
      if (int'(tcount) < TIMEOUT_CYCLES) begin
        tcount <= tcount + CW'(1);
      end
      if (int'(tcount) + 1 >= TIMEOUT_CYCLES) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_celement_merge_sync.sv
// Directed bench for celement_merge_sync: transaction-level token model checked every cycle
// plus literal expectations for each scenario.
module tb_celement_merge_sync;
  localparam int DW = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          sendina, sendinb, ackin;
  logic [DW-1:0] dataina, datainb;
  logic          ackouta, ackoutb, sendout, brout, err;
  logic [DW-1:0] dataout;

  int checks = 0;
  int errors = 0;

  celement_merge_sync #(.DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .sendina(sendina), .dataina(dataina), .ackouta(ackouta),
    .sendinb(sendinb), .datainb(datainb), .ackoutb(ackoutb),
    .sendout(sendout), .dataout(dataout), .brout(brout),
    .ackin(ackin), .err(err)
  );

  always #5 clk = ~clk;

  // Token-level model: one token in flight, either awaiting delivery or awaiting release.
  logic          m_valid = 1'b0;
  logic          m_busy, m_deliv, m_src, m_lastb, m_err, m_br;
  logic [DW-1:0] m_data;
  int            m_wait;

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b1;
      m_busy  <= 1'b0;
      m_deliv <= 1'b0;
      m_src   <= 1'b0;
      m_lastb <= 1'b1;
      m_err   <= 1'b0;
      m_br    <= 1'b0;
      m_data  <= '0;
      m_wait  <= 0;
    end else if (!m_busy) begin
      if (sendina && (!sendinb || m_lastb)) begin
        m_busy <= 1'b1; m_deliv <= 1'b0; m_src <= 1'b0; m_lastb <= 1'b0;
        m_br <= 1'b0; m_data <= dataina; m_wait <= 0;
      end else if (sendinb) begin
        m_busy <= 1'b1; m_deliv <= 1'b0; m_src <= 1'b1; m_lastb <= 1'b1;
        m_br <= 1'b1; m_data <= datainb; m_wait <= 0;
      end
    end else if (!m_deliv) begin
      if (ackin) begin
        m_deliv <= 1'b1;
      end else begin
        m_wait <= m_wait + 1;
`ifdef CELEMENT_MERGE_TIMEOUT_EN
        if (m_wait + 1 >= TO) m_err <= 1'b1;
`endif
      end
    end else if (!ackin && !(m_src ? sendinb : sendina)) begin
      m_busy  <= 1'b0;
      m_deliv <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("cmp_sendout", 32'(sendout), 32'(m_busy && !m_deliv));
      checkOutput("cmp_ackouta", 32'(ackouta), 32'(m_busy && m_deliv && !m_src));
      checkOutput("cmp_ackoutb", 32'(ackoutb), 32'(m_busy && m_deliv && m_src));
      checkOutput("cmp_dataout", 32'(dataout), 32'(m_data));
      checkOutput("cmp_brout",   32'(brout),   32'(m_br));
      checkOutput("cmp_err",     32'(err),     32'(m_err));
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic a, input logic [DW-1:0] da,
                               input logic b, input logic [DW-1:0] db, input logic ack);
    sendina = a; dataina = da; sendinb = b; datainb = db; ackin = ack;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  // Waits for a grant, checks it, completes the four-phase handshake, optionally re-raises the request.
  task automatic serveOne(input logic expBr, input logic [DW-1:0] expData, input logic rearm);
    int n;
    n = 0;
    while (!sendout && n < 20) begin tick(1); n++; end
    checkOutput("grant_seen", 32'(sendout), 32'd1);
    checkOutput("grant_br", 32'(brout), 32'(expBr));
    checkOutput("grant_data", 32'(dataout), 32'(expData));
    ackin = 1'b1;
    n = 0;
    while (!(expBr ? ackoutb : ackouta) && n < 20) begin tick(1); n++; end
    checkOutput("ack_seen", 32'(expBr ? ackoutb : ackouta), 32'd1);
    ackin = 1'b0;
    if (expBr) sendinb = 1'b0; else sendina = 1'b0;
    tick(1);
    checkOutput("ack_release", 32'(expBr ? ackoutb : ackouta), 32'd0);
    if (rearm) begin
      if (expBr) sendinb = 1'b1; else sendina = 1'b1;
    end
  endtask

  initial begin
    int grants;
    logic sawA, prevSend;

    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    tick(2);
    checkOutput("reset_sendout", 32'(sendout), 32'd0);
    checkOutput("reset_acks", 32'({ackouta, ackoutb}), 32'd0);
    checkOutput("reset_dataout", 32'(dataout), 32'd0);
    checkOutput("reset_brout_err", 32'({brout, err}), 32'd0);
    reset = 1'b0;
    tick(1);

    $display("[TB] single A token");
    applyStimulus(1'b1, 8'h5A, 1'b0, '0, 1'b0);
    tick(1);
    checkOutput("a_sendout", 32'(sendout), 32'd1);
    checkOutput("a_dataout", 32'(dataout), 32'h5A);
    checkOutput("a_brout", 32'(brout), 32'd0);
    tick(2);
    ackin = 1'b1;
    tick(1);
    checkOutput("a_ackouta", 32'(ackouta), 32'd1);
    checkOutput("a_sendout_low", 32'(sendout), 32'd0);
    ackin = 1'b0;
    sendina = 1'b0;
    tick(1);
    checkOutput("a_ackouta_low", 32'(ackouta), 32'd0);
    tick(1);

    $display("[TB] simultaneous requests alternate");
    resetDut();
    applyStimulus(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
    serveOne(1'b0, 8'h11, 1'b1);
    serveOne(1'b1, 8'h22, 1'b1);
    serveOne(1'b0, 8'h11, 1'b1);
    serveOne(1'b1, 8'h22, 1'b0);
    serveOne(1'b0, 8'h11, 1'b0);
    tick(1);

    $display("[TB] slow source release");
    resetDut();
    applyStimulus(1'b1, 8'h33, 1'b1, 8'h44, 1'b0);
    tick(1);
    checkOutput("slow_grant_a", 32'({sendout, brout}), 32'b10);
    ackin = 1'b1;
    tick(1);
    ackin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput("slow_hold_ack", 32'({ackouta, ackoutb, sendout}), 32'b100);
    end
    sendina = 1'b0;
    tick(1);
    checkOutput("slow_release", 32'(ackouta), 32'd0);
    serveOne(1'b1, 8'h44, 1'b0);
    tick(1);

    $display("[TB] reset mid-REQ");
    applyStimulus(1'b1, 8'h55, 1'b0, '0, 1'b0);
    tick(1);
    checkOutput("rst_pre_sendout", 32'(sendout), 32'd1);
    reset = 1'b1;
    tick(1);
    checkOutput("rst_outputs", 32'({sendout, ackouta, ackoutb, brout, err}), 32'd0);
    reset = 1'b0;
    sendinb = 1'b1;
    datainb = 8'h66;
    serveOne(1'b0, 8'h55, 1'b0);
    serveOne(1'b1, 8'h66, 1'b0);
    tick(1);

    $display("[TB] back-to-back B");
    grants = 0;
    sawA = 1'b0;
    prevSend = sendout;
    applyStimulus(1'b0, '0, 1'b1, 8'h70, 1'b0);
    for (int i = 0; i < 24; i++) begin
      tick(1);
      if (sendout && !prevSend) begin
        grants++;
        datainb = 8'h70 + 8'(grants);
      end
      prevSend = sendout;
      if (ackouta) sawA = 1'b1;
      ackin = sendout;
      sendinb = !ackoutb;
    end
    sendinb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (ackouta) sawA = 1'b1;
      ackin = sendout;
    end
    ackin = 1'b0;
    checkOutput("b2b_no_ackouta", 32'(sawA), 32'd0);
    checkOutput("b2b_enough_tokens", 32'(grants >= 5), 32'd1);
    tick(1);

`ifdef CELEMENT_MERGE_TIMEOUT_EN
    $display("[TB] timeout");
    resetDut();
    applyStimulus(1'b1, 8'h99, 1'b0, '0, 1'b0);
    tick(1);
    tick(3);
    checkOutput("to_err_before", 32'(err), 32'd0);
    tick(1);
    checkOutput("to_err_set", 32'(err), 32'd1);
    ackin = 1'b1;
    tick(1);
    ackin = 1'b0;
    sendina = 1'b0;
    tick(2);
    checkOutput("to_err_sticky", 32'(err), 32'd1);
    resetDut();
    checkOutput("to_err_cleared", 32'(err), 32'd0);
`else
    $display("[TB] err tied low");
    applyStimulus(1'b1, 8'h99, 1'b0, '0, 1'b0);
    tick(10);
    checkOutput("noto_err", 32'(err), 32'd0);
    ackin = 1'b1;
    tick(1);
    ackin = 1'b0;
    sendina = 1'b0;
    tick(2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
